// File: rtl/mdio_master_mc.sv
// Multi-bus MDIO (Clause 22 / Clause 45) master: one frame engine whose MDC/MDIO
// pins are steered onto the bus selected by each command.
module mdio_master_mc #(
  parameter int N_BUS   = 2,
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32,
  localparam int BW     = (N_BUS > 1) ? $clog2(N_BUS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [BW-1:0]    cmd_bus,
  input  logic             cmd_st,
  input  logic [1:0]       cmd_op,
  input  logic [4:0]       cmd_phyad,
  input  logic [4:0]       cmd_regad,
  input  logic [15:0]      cmd_wdata,
  output logic             rsp_valid,
  output logic [15:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [N_BUS-1:0] mdc,
  output logic [N_BUS-1:0] mdio_o,
  output logic [N_BUS-1:0] mdio_oe,
  input  logic [N_BUS-1:0] mdio_i
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);
  localparam logic [4:0]    PRE_LAST = 5'((PRE_LEN == 0) ? 0 : PRE_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_TA, S_DATA, S_TAIL} state_t;

  state_t            state, state_nxt;
  logic [DW-1:0]     div_cnt;
  logic [4:0]        bit_cnt;
  logic [N_BUS-1:0]  sync1, sync2;
  logic [BW-1:0]     bus_q;
  logic              is_rd;
  logic [31:0]       shreg;
  logic              err_q;
  logic [15:0]       rd_q;
  logic              accept, bad_bus, bit_end, sample, oe_cur, drv_bit;

  assign cmd_ready = rst_n && (state == S_IDLE);
  assign accept    = cmd_valid && (state == S_IDLE);
  assign bad_bus   = (32'(cmd_bus) >= 32'(N_BUS));
  assign bit_end   = (div_cnt == DIV_LAST);

  always_comb begin
    sample = 1'b1;
    for (int i = 0; i < N_BUS; i++)
      if (bus_q == BW'(i)) sample = sync2[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oe_cur    = 1'b0;
    drv_bit   = 1'b1;
    case (state)
      S_IDLE: if (accept && !bad_bus) state_nxt = (PRE_LEN == 0) ? S_HDR : S_PRE;
      S_PRE: begin
        oe_cur = 1'b1;
        if (bit_end && bit_cnt == PRE_LAST) state_nxt = S_HDR;
      end
      S_HDR: begin
        oe_cur  = 1'b1;
        drv_bit = shreg[31];
        if (bit_end && bit_cnt == 5'd13) state_nxt = S_TA;
      end
      S_TA: begin
        oe_cur  = !is_rd;
        drv_bit = shreg[31];
        if (bit_end && bit_cnt == 5'd1) state_nxt = S_DATA;
      end
      S_DATA: begin
        oe_cur  = !is_rd;
        drv_bit = shreg[31];
        if (bit_end && bit_cnt == 5'd15) state_nxt = S_TAIL;
      end
      S_TAIL: if (bit_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit timing, pad synchronisers and the response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sync1     <= '1;
      sync2     <= '1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      sync1     <= mdio_i;
      sync2     <= sync1;
      rsp_valid <= 1'b0;
      if (state == S_IDLE) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        if (accept && bad_bus) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end else begin
        div_cnt <= bit_end ? '0 : div_cnt + DW'(1);
        if (bit_end) begin
          bit_cnt <= (state_nxt != state) ? 5'd0 : bit_cnt + 5'd1;
          if (state == S_TAIL) begin
            rsp_valid <= 1'b1;
            rsp_err   <= is_rd & err_q;
            rsp_rdata <= is_rd ? rd_q : 16'h0000;
          end
        end
      end
    end
  end

  // Frame shifter: ST OP PHYAD REGAD TA DATA, shifted out MSB first at bit ends
  always_ff @(posedge clk) begin
    if (accept && !bad_bus) begin
      bus_q <= cmd_bus;
      is_rd <= cmd_op[1];
      shreg <= {1'b0, cmd_st, cmd_op, cmd_phyad, cmd_regad, 2'b10, cmd_wdata};
    end else if (bit_end && state != S_IDLE) begin
      if (state == S_HDR || state == S_TA || state == S_DATA)
        shreg <= {shreg[30:0], 1'b1};
      if (state == S_TA && bit_cnt == 5'd1) err_q <= sample;
      if (state == S_DATA) rd_q <= {rd_q[14:0], sample};
    end
  end

  always_comb begin
    mdc     = '0;
    mdio_oe = '0;
    mdio_o  = '1;
    for (int i = 0; i < N_BUS; i++) begin
      if (state != S_IDLE && bus_q == BW'(i)) begin
        mdc[i]     = (div_cnt >= DIV_HALF);
        mdio_oe[i] = oe_cur;
        mdio_o[i]  = oe_cur ? drv_bit : 1'b1;
      end
    end
  end

endmodule

// File: doc/mdio_master_mc.md
MDIO_MASTER_MC -- requirements
Module: mdio_master_mc

Interface
REQ-001 Parameter N_BUS, default 2: number of independent MDIO buses (1..8).
REQ-002 Parameter CLK_DIV, default 10: clk cycles per MDC half-period (>=2); MDC = f_clk/(2*CLK_DIV).
REQ-003 Parameter PRE_LEN, default 32: preamble length in bits (0..32).
REQ-004 Local BW = max(1, clog2(N_BUS)).
REQ-005 clk  input  1  system clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 cmd_valid  input  1  command request.
REQ-008 cmd_ready  output  1  module can accept a command.
REQ-009 cmd_bus  input  BW  target bus index.
REQ-010 cmd_st  input  1  1 = Clause 22 frame (ST=01), 0 = Clause 45 frame (ST=00).
REQ-011 cmd_op  input  2  OP field, sent MSB first (C22: 01 wr, 10 rd; C45: 00 addr, 01 wr, 11 rd, 10 rd-inc).
REQ-012 cmd_phyad  input  5  PHYAD / PRTAD.
REQ-013 cmd_regad  input  5  REGAD / DEVAD.
REQ-014 cmd_wdata  input  16  write data, or address for C45 op 00.
REQ-015 rsp_valid  output  1  one-cycle completion pulse.
REQ-016 rsp_rdata  output  16  read data, valid with rsp_valid.
REQ-017 rsp_err  output  1  error flag, valid with rsp_valid.
REQ-018 mdc  output  N_BUS  per-bus management clock.
REQ-019 mdio_o  output  N_BUS  per-bus MDIO output value.
REQ-020 mdio_oe  output  N_BUS  per-bus MDIO output enable (1 = drive).
REQ-021 mdio_i  input  N_BUS  per-bus MDIO pad input (asynchronous).

Function
REQ-022 A command is read-type when cmd_op[1]=1, otherwise write-type (C45 op 00 included).
REQ-023 cmd_ready = 1 only in IDLE; a command is accepted on a clk edge with cmd_valid & cmd_ready; all cmd_* are captured then.
REQ-024 If cmd_bus >= N_BUS: no frame; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0; return to IDLE.
REQ-025 States: IDLE -> PRE (skipped if PRE_LEN=0) -> HDR -> TA -> DATA -> TAIL -> IDLE.
REQ-026 Bit timing: each bit lasts 2*CLK_DIV clk; MDC low for the first CLK_DIV cycles, high for the second CLK_DIV; the first bit's low phase starts the cycle after acceptance.
REQ-027 Drive data changes only at the start of a bit (MDC low phase).
REQ-028 Read data is sampled from a 2-flop synchronised mdio_i on the last clk of the MDC high phase.
REQ-029 PRE: PRE_LEN bits of 1, oe=1.
REQ-030 HDR: 14 bits, ST(2), OP(2), PHYAD(5), REGAD(5), MSB first, oe=1.
REQ-031 TA write-type: drive 1 then 0, oe=1.
REQ-032 TA read-type: oe=0 for both bits; the sampled second TA bit is 1 -> rsp_err=1 (no PHY response); the frame still completes.
REQ-033 DATA write-type: cmd_wdata[15:0] MSB first, oe=1.
REQ-034 DATA read-type: oe=0; 16 samples shifted MSB first into rsp_rdata.
REQ-035 TAIL: one bit time with oe=0 and MDC toggling; rsp_valid pulses on the cycle after TAIL ends; cmd_ready=1 in that same cycle.
REQ-036 Total busy time = (PRE_LEN+33)*2*CLK_DIV clk from acceptance to rsp_valid.
REQ-037 Write-type completion: rsp_rdata=0, rsp_err=0.
REQ-038 Only the selected bus toggles MDC or asserts oe; unselected buses hold mdc=0, oe=0, mdio_o=1.
REQ-039 In IDLE all buses: mdc=0, oe=0, mdio_o=1.
REQ-040 cmd_valid held during busy is ignored until IDLE; there is no rsp backpressure.

Reset
REQ-041 rst_n low asynchronously forces IDLE: mdc=0, mdio_oe=0, mdio_o=all 1, cmd_ready=0 while asserted then 1, rsp_valid=0, rsp_rdata=0, rsp_err=0, sync flops=1.
REQ-042 Reset mid-frame aborts with no rsp_valid; first command after release produces a full frame from PRE.

Verification
REQ-043 C22 write, bus 1, PHYAD 3, REGAD 0x04, data 0xA5C3, CLK_DIV=10, PRE_LEN=32 -> bus 1 shows 32 ones, 01 01 00011 00100 10 1010010111000011; rsp_valid at 1300 clk; rsp_err=0; bus 0 idle.
REQ-044 C22 read, PHY model drives TA0=0 and 0x1234 -> oe=0 from TA; rsp_rdata=0x1234, rsp_err=0.
REQ-045 C45 read, mdio_i pulled high (no PHY) -> rsp_err=1, rsp_rdata=0xFFFF, frame length unchanged.
REQ-046 cmd_bus=N_BUS -> rsp_valid with rsp_err=1 the next cycle; no MDC activity on any bus.
REQ-047 PRE_LEN=0, CLK_DIV=2, C45 addr op 00 with data 0x0010 -> frame starts with ST=00; rsp_valid 132 clk after acceptance.
REQ-048 rst_n asserted at HDR bit 5 -> outputs reach reset values immediately; no rsp_valid; next command completes normally.
